vault_phase_sequencer: RTL and testbench
========================================

# vault_phase_sequencer

Parametrised phase controller for the vault puzzle chain. It enables one puzzle phase at a time, clears each phase block before arming it, and advances on that phase's done pulse. On a fail or a per-phase timeout it rolls back to a configurable phase, and it enters a timed lockout after too many failures. It sits above the phase blocks in the vault top level and replaces hard-wired phase chaining, generalising to NUM_PHASES phases.

## Interface
Parameters:
- NUM_PHASES, 5, number of chained phases (2..16); phase index 0-based
- ROLLBACK_PHASE, 1, phase index re-entered after a fail in a late phase
- ROLLBACK_FROM, 2, fails in phase index >= ROLLBACK_FROM roll back to ROLLBACK_PHASE; fails below it retry the same phase (ROLLBACK_PHASE < ROLLBACK_FROM)
- MAX_FAILS, 3, total failures (fails + timeouts) that trigger lockout (>= 1)
- TIMEOUT, 64, RUN cycles allowed per phase attempt; 0 disables the timeout
- LOCKOUT_CYCLES, 256, duration of lockout (>= 1)

Ports:
- clk  in  1  clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins or restarts the sequence from phase 0
- abort  in  1  returns to IDLE; ignored in LOCKOUT
- phase_done  in  NUM_PHASES  per-phase done pulses
- phase_fail  in  NUM_PHASES  per-phase fail pulses
- phase_en  out  NUM_PHASES  one-hot enable of the active phase
- phase_clear  out  NUM_PHASES  one-cycle clear pulse to the phase about to be armed
- cur_phase  out  $clog2(NUM_PHASES)  active or target phase index
- fail_count  out  $clog2(MAX_FAILS+1)  failures in the current run
- timed_out  out  1  one-cycle pulse when a timeout is taken
- all_done  out  1  high while in DONE
- locked_out  out  1  high while in LOCKOUT

## Operation
- All outputs are registered.
- States: IDLE, CLEAR, RUN, DONE, LOCKOUT.
- IDLE: phase_en=0. On start: cur_phase=0, fail_count=0, go to CLEAR.
- CLEAR (exactly 1 cycle): phase_clear[cur_phase]=1, phase_en=0. Reload the timer to 0, then go to RUN.
- RUN: phase_en[cur_phase]=1. Only bit cur_phase of phase_done/phase_fail is examined; all other bits are ignored.
- Event priority in RUN: fail > done > timeout. The timeout fires when the timer reaches TIMEOUT-1 with no done or fail that cycle.
- On done: if cur_phase==NUM_PHASES-1, go to DONE; otherwise cur_phase+1, go to CLEAR.
- On fail or timeout:
  - Increment fail_count, saturating at MAX_FAILS.
  - If the new count equals MAX_FAILS, go to LOCKOUT.
  - Otherwise set cur_phase = (cur_phase >= ROLLBACK_FROM) ? ROLLBACK_PHASE : cur_phase, and go to CLEAR.
- DONE: all_done=1 and phase_en=0; cur_phase holds NUM_PHASES-1. start restarts the sequence (go to CLEAR, counters cleared).
- LOCKOUT: locked_out=1, phase_en=0. start and abort are ignored. After LOCKOUT_CYCLES cycles, go to IDLE; fail_count holds its value until the next start.
- abort in CLEAR, RUN or DONE goes to IDLE next cycle. fail_count and cur_phase hold; all_done and phase_en drop.
- start and abort in the same cycle: abort wins.
- start while in CLEAR or RUN restarts from phase 0 with fail_count=0.
- Width rule: the timer width is $clog2(TIMEOUT+1), minimum 1.

## Timing
- Reset: state=IDLE, phase_en=0, phase_clear=0, cur_phase=0, fail_count=0, timed_out=0, all_done=0, locked_out=0, timer and lockout counter 0. Reset applied mid-RUN or mid-LOCKOUT produces these values on the next edge.
- start sampled at edge t: phase_clear[0]=1 during cycle t+1, phase_en[0]=1 from cycle t+2.
- done/fail sampled at edge t: phase_en drops at t+1 (CLEAR for the target phase), and the new phase_en asserts at t+2.
- Final done at t: all_done=1 from t+1.
- Timeout: the first RUN cycle is timer=0. With no event, the timeout is taken at RUN cycle TIMEOUT-1, and timed_out pulses in the following cycle alongside CLEAR or LOCKOUT entry.
- Lockout: locked_out is high for exactly LOCKOUT_CYCLES cycles; state is IDLE on the next cycle.
- Done on the same cycle as timer expiry: done is taken, no timeout.

## Test plan
- Happy path (defaults): start, then pulse phase_done[i] 3 cycles after each phase_en[i] -> phase_en walks 00001..10000, each preceded by a 1-cycle phase_clear; all_done=1 one cycle after phase_done[4]; fail_count=0.
- Rollback: fail in phase 3 -> phase_clear[1] next cycle, cur_phase=1, fail_count=1. Fail in phase 0 -> phase_clear[0], cur_phase stays 0.
- Lockout: 3 fails -> locked_out high for exactly 256 cycles with start pulses ignored, then IDLE with fail_count=3. A subsequent start clears fail_count to 0.
- Timeout: arm phase 2 and give no response -> timed_out pulse after 64 RUN cycles, cur_phase=1, fail_count=1. Done on cycle 63 -> advance, no timed_out.
- Collisions: phase_done[2] and phase_fail[2] in the same cycle -> treated as fail. A pulse on a non-active bit (phase_done[4] during phase 1) -> ignored. start and abort together -> IDLE.
- Reset mid-RUN in phase 3 -> all outputs at reset values next cycle; start then arms phase 0.

Source files
------------

// File: rtl/vault_phase_sequencer.sv
// vault_phase_sequencer
//
// Phase controller for the vault puzzle chain. Arms one puzzle phase at a time.
// Each phase gets a one-cycle clear pulse and is then enabled. The controller
// advances on that phase's done pulse. A fail or a per-phase timeout either
// retries the phase or rolls back to ROLLBACK_PHASE. Too many failures in one
// run force a timed lockout.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        begin / restart the sequence from phase 0
//   abort        return to idle (ignored during lockout, wins over start)
//   phase_done   per-phase done pulses (only the active bit is examined)
//   phase_fail   per-phase fail pulses (only the active bit is examined)
//   phase_en     one-hot enable of the running phase
//   phase_clear  one-cycle clear pulse to the phase about to be armed
//   cur_phase    active or target phase index
//   fail_count   failures (fails + timeouts) in the current run
//   timed_out    one-cycle pulse after a timeout is taken
//   all_done     high while the whole chain is complete
//   locked_out   high while in lockout
module vault_phase_sequencer #(
  parameter int unsigned NUM_PHASES     = 5,
  parameter int unsigned ROLLBACK_PHASE = 1,
  parameter int unsigned ROLLBACK_FROM  = 2,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned TIMEOUT        = 64,
  parameter int unsigned LOCKOUT_CYCLES = 256,
  localparam int unsigned PhaseW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  localparam int unsigned FailW  = (MAX_FAILS > 0) ? $clog2(MAX_FAILS + 1) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic [NUM_PHASES-1:0] phase_fail,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [NUM_PHASES-1:0] phase_clear,
  output logic [PhaseW-1:0]     cur_phase,
  output logic [FailW-1:0]      fail_count,
  output logic                  timed_out,
  output logic                  all_done,
  output logic                  locked_out
);

  localparam int unsigned TimerW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LockW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [TimerW-1:0] TimerLast = TimerW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LockW-1:0]  LockLast  = LockW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
  localparam logic [FailW-1:0]  FailMax   = FailW'(MAX_FAILS);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDone,
    StLockout
  } state_e;

  state_e                state_q, state_d;
  logic [PhaseW-1:0]     cur_phase_q, cur_phase_d;
  logic [FailW-1:0]      fail_count_q, fail_count_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [LockW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
  logic [NUM_PHASES-1:0] phase_clear_q, phase_clear_d;
  logic                  timed_out_q, timed_out_d;
  logic                  all_done_q, all_done_d;
  logic                  locked_out_q, locked_out_d;

  logic                  evt_done, evt_fail, timer_hit, timeout_take;
  logic [FailW-1:0]      fail_next;

  // Only the active phase's pulses matter.
  assign evt_done  = phase_done[cur_phase_q];
  assign evt_fail  = phase_fail[cur_phase_q];
  assign timer_hit = (TIMEOUT != 0) && (timer_q == TimerLast);
  assign fail_next = (fail_count_q >= FailMax) ? fail_count_q : fail_count_q + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cur_phase_q   <= '0;
      fail_count_q  <= '0;
      timer_q       <= '0;
      lock_cnt_q    <= '0;
      phase_en_q    <= '0;
      phase_clear_q <= '0;
      timed_out_q   <= 1'b0;
      all_done_q    <= 1'b0;
      locked_out_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_phase_q   <= cur_phase_d;
      fail_count_q  <= fail_count_d;
      timer_q       <= timer_d;
      lock_cnt_q    <= lock_cnt_d;
      phase_en_q    <= phase_en_d;
      phase_clear_q <= phase_clear_d;
      timed_out_q   <= timed_out_d;
      all_done_q    <= all_done_d;
      locked_out_q  <= locked_out_d;
    end
  end

  // Next-state logic. Priority: abort > start > fail > done > timeout.
  always_comb begin
    state_d      = state_q;
    cur_phase_d  = cur_phase_q;
    fail_count_d = fail_count_q;
    timer_d      = '0;
    lock_cnt_d   = '0;
    timeout_take = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!abort && start) begin
          state_d      = StClear;
          cur_phase_d  = '0;
          fail_count_d = '0;
        end
      end

      StClear, StRun, StDone: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          state_d      = StClear;
          cur_phase_d  = '0;
          fail_count_d = '0;
        end else if (state_q == StClear) begin
          state_d = StRun;
        end else if (state_q == StRun) begin
          if (evt_fail || (!evt_done && timer_hit)) begin
            timeout_take = !evt_fail;
            fail_count_d = fail_next;
            if (fail_next == FailMax) begin
              state_d = StLockout;
            end else begin
              state_d = StClear;
              if (32'(cur_phase_q) >= ROLLBACK_FROM) begin
                cur_phase_d = PhaseW'(ROLLBACK_PHASE);
              end
            end
          end else if (evt_done) begin
            if (32'(cur_phase_q) == NUM_PHASES - 1) begin
              state_d = StDone;
            end else begin
              state_d     = StClear;
              cur_phase_d = cur_phase_q + 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      StLockout: begin
        // Counter starts at 0 on entry, so the state lasts LOCKOUT_CYCLES cycles.
        if (lock_cnt_q == LockLast) begin
          state_d = StIdle;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state; every output leaves through a register.
  always_comb begin
    phase_en_d    = '0;
    phase_clear_d = '0;
    if (state_d == StRun) begin
      phase_en_d = NUM_PHASES'(1) << cur_phase_d;
    end
    if (state_d == StClear) begin
      phase_clear_d = NUM_PHASES'(1) << cur_phase_d;
    end
    timed_out_d  = timeout_take;
    all_done_d   = (state_d == StDone);
    locked_out_d = (state_d == StLockout);
  end

  assign phase_en    = phase_en_q;
  assign phase_clear = phase_clear_q;
  assign cur_phase   = cur_phase_q;
  assign fail_count  = fail_count_q;
  assign timed_out   = timed_out_q;
  assign all_done    = all_done_q;
  assign locked_out  = locked_out_q;

endmodule

// File: tb/tb_vault_phase_sequencer.sv
module tb_vault_phase_sequencer;

  localparam int N      = 5;
  localparam int RBP    = 1;
  localparam int RBF    = 2;
  localparam int MAXF   = 3;
  localparam int TO     = 64;
  localparam int LOCK   = 256;
  localparam int PW     = $clog2(N);
  localparam int FW     = $clog2(MAXF + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  phase_done = '0;
  logic [N-1:0]  phase_fail = '0;
  logic [N-1:0]  phase_en;
  logic [N-1:0]  phase_clear;
  logic [PW-1:0] cur_phase;
  logic [FW-1:0] fail_count;
  logic          timed_out;
  logic          all_done;
  logic          locked_out;

  always #5 clk = ~clk;

  vault_phase_sequencer #(
    .NUM_PHASES    (N),
    .ROLLBACK_PHASE(RBP),
    .ROLLBACK_FROM (RBF),
    .MAX_FAILS     (MAXF),
    .TIMEOUT       (TO),
    .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .phase_done (phase_done),
    .phase_fail (phase_fail),
    .phase_en   (phase_en),
    .phase_clear(phase_clear),
    .cur_phase  (cur_phase),
    .fail_count (fail_count),
    .timed_out  (timed_out),
    .all_done   (all_done),
    .locked_out (locked_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: what the controller should show after each edge.
  int m_phase = 0;
  int m_fails = 0;
  int m_age = 0;        // cycles spent enabled in the current attempt
  int m_lock_left = 0;  // lockout cycles still to be shown
  bit m_clear = 0;
  bit m_run = 0;
  bit m_done = 0;
  bit m_to = 0;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic void model_step(input logic r, input logic s, input logic a,
                                     input logic [N-1:0] d, input logic [N-1:0] f);
    bit hit_fail, hit_done, expire;
    m_to = 0;
    if (r) begin
      m_phase = 0; m_fails = 0; m_age = 0; m_lock_left = 0;
      m_clear = 0; m_run = 0; m_done = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
    end else if (a) begin
      m_clear = 0; m_run = 0; m_done = 0;
    end else if (s) begin
      m_phase = 0; m_fails = 0; m_clear = 1; m_run = 0; m_done = 0;
    end else if (m_clear) begin
      m_clear = 0; m_run = 1; m_age = 0;
    end else if (m_run) begin
      hit_fail = f[m_phase];
      hit_done = d[m_phase];
      expire   = (TO > 0) && (m_age == TO - 1);
      if (hit_fail || (!hit_done && expire)) begin
        m_to    = !hit_fail;
        m_fails = (m_fails + 1 > MAXF) ? MAXF : m_fails + 1;
        m_run   = 0;
        if (m_fails == MAXF) begin
          m_lock_left = LOCK;
        end else begin
          if (m_phase >= RBF) m_phase = RBP;
          m_clear = 1;
        end
      end else if (hit_done) begin
        m_run = 0;
        if (m_phase == N - 1) m_done = 1;
        else begin
          m_phase++;
          m_clear = 1;
        end
      end else begin
        m_age++;
      end
    end
  endfunction

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic cyc(input logic s, input logic a, input logic [N-1:0] d,
                     input logic [N-1:0] f, input logic r);
    reset = r; start = s; abort = a; phase_done = d; phase_fail = f;
    model_step(r, s, a, d, f);
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; abort = 1'b0; phase_done = '0; phase_fail = '0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic go();
    cyc(1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rst();
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic done_p(input int i);
    cyc(1'b0, 1'b0, oh(i), '0, 1'b0);
  endtask

  task automatic check(input string name, input logic [N-1:0] en, input logic [N-1:0] clr,
                       input int cp, input int fc, input int to, input int dn, input int lk);
    n_vec++;
    if (phase_en !== en || phase_clear !== clr || cur_phase !== PW'(cp) ||
        fail_count !== FW'(fc) || timed_out !== 1'(to) || all_done !== 1'(dn) ||
        locked_out !== 1'(lk)) begin
      n_bad++;
      $display("FAIL %s @%0t: got en=%b clr=%b cp=%0d fc=%0d to=%b dn=%b lk=%b, want en=%b clr=%b cp=%0d fc=%0d to=%0d dn=%0d lk=%0d",
               name, $time, phase_en, phase_clear, cur_phase, fail_count, timed_out, all_done,
               locked_out, en, clr, cp, fc, to, dn, lk);
    end
  endtask

  task automatic check_model(input string name);
    logic [N-1:0] en, clr;
    en  = m_run ? oh(m_phase) : '0;
    clr = m_clear ? oh(m_phase) : '0;
    check(name, en, clr, m_phase, m_fails, int'(m_to), int'(m_done), int'(m_lock_left > 0));
  endtask

  typedef struct {
    int           s, a;
    logic [N-1:0] d, f;
    logic [N-1:0] en, clr;
    int           cp, fc, to, dn, lk;
  } vec_t;

  vec_t tbl[27];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_evt, p_start;
    logic [N-1:0] rd, rf;
    logic rs, ra, rr;

    // {start, abort, done, fail} -> {en, clr, cur_phase, fail_count, timed_out, all_done, locked}
    tbl[0]  = '{0, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00010, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 5'b10000, 5'b00000, 5'b00010, 5'b00000, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 5'b00010, 5'b00000, 5'b00000, 5'b00100, 2, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 2, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 5'b00100, 5'b00100, 5'b00000, 5'b00010, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 1, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 5'b00000, 5'b00010, 5'b00000, 5'b00010, 1, 2, 0, 0, 0};
    tbl[11] = '{0, 0, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 1, 2, 0, 0, 0};
    tbl[12] = '{1, 1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 2, 0, 0, 0};
    tbl[13] = '{1, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 0, 0, 0, 0, 0};
    tbl[15] = '{0, 0, 5'b00000, 5'b00001, 5'b00000, 5'b00001, 0, 1, 0, 0, 0};
    tbl[16] = '{0, 0, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 0, 1, 0, 0, 0};
    tbl[17] = '{0, 0, 5'b00001, 5'b00000, 5'b00000, 5'b00010, 1, 1, 0, 0, 0};
    tbl[18] = '{0, 0, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 1, 1, 0, 0, 0};
    tbl[19] = '{0, 0, 5'b00010, 5'b00000, 5'b00000, 5'b00100, 2, 1, 0, 0, 0};
    tbl[20] = '{0, 0, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 2, 1, 0, 0, 0};
    tbl[21] = '{0, 0, 5'b00100, 5'b00000, 5'b00000, 5'b01000, 3, 1, 0, 0, 0};
    tbl[22] = '{0, 0, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 3, 1, 0, 0, 0};
    tbl[23] = '{0, 0, 5'b00000, 5'b01000, 5'b00000, 5'b00010, 1, 2, 0, 0, 0};
    tbl[24] = '{0, 0, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 1, 2, 0, 0, 0};
    tbl[25] = '{0, 0, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 1, 3, 0, 0, 1};
    tbl[26] = '{1, 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1, 3, 0, 0, 1};

    // Reset state
    rst();
    rst();
    check("reset_state", '0, '0, 0, 0, 0, 0, 0);

    // Table: walk, non-active pulse, done+fail collision, rollback, retry,
    // start+abort, lockout entry with start ignored
    for (int i = 0; i < 27; i++) begin
      cyc(1'(tbl[i].s), 1'(tbl[i].a), tbl[i].d, tbl[i].f, 1'b0);
      check($sformatf("table[%0d]", i), tbl[i].en, tbl[i].clr, tbl[i].cp, tbl[i].fc,
            tbl[i].to, tbl[i].dn, tbl[i].lk);
    end

    // Lockout lasts exactly LOCK cycles; start/abort ignored throughout
    for (int k = 0; k < LOCK - 2; k++) begin
      cyc(1'((k % 7) == 0), 1'((k % 11) == 5), '0, '0, 1'b0);
      check("lockout_hold", '0, '0, 1, 3, 0, 0, 1);
    end
    idle();
    check("lockout_exit", '0, '0, 1, 3, 0, 0, 0);
    go();
    check("restart_after_lockout", '0, oh(0), 0, 0, 0, 0, 0);

    // Happy path: done three cycles after each enable
    rst();
    go();
    check("happy_clear0", '0, oh(0), 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      idle();
      check("happy_enable", oh(i), '0, i, 0, 0, 0, 0);
      idle();
      idle();
      done_p(i);
      if (i < N - 1) check("happy_advance", '0, oh(i + 1), i + 1, 0, 0, 0, 0);
      else check("happy_all_done", '0, '0, N - 1, 0, 0, 1, 0);
    end
    idle();
    check("done_hold", '0, '0, N - 1, 0, 0, 1, 0);
    cyc(1'b0, 1'b1, '0, '0, 1'b0);
    check("done_abort", '0, '0, N - 1, 0, 0, 0, 0);

    // Timeout in phase 2, then done on the last allowed cycle in phase 1
    rst();
    go();
    idle();
    done_p(0);
    idle();
    done_p(1);
    idle();
    check("to_armed", oh(2), '0, 2, 0, 0, 0, 0);
    for (int k = 0; k < TO - 1; k++) begin
      idle();
      check("to_wait", oh(2), '0, 2, 0, 0, 0, 0);
    end
    idle();
    check("to_taken", '0, oh(1), 1, 1, 1, 0, 0);
    idle();
    check("to_rearm", oh(1), '0, 1, 1, 0, 0, 0);
    for (int k = 0; k < TO - 1; k++) idle();
    done_p(1);
    check("done_at_expiry", '0, oh(2), 2, 1, 0, 0, 0);

    // Reset in the middle of phase 3
    idle();
    done_p(2);
    idle();
    check("p3_run", oh(3), '0, 3, 1, 0, 0, 0);
    rst();
    check("reset_mid_run", '0, '0, 0, 0, 0, 0, 0);
    go();
    check("post_reset_clear", '0, oh(0), 0, 0, 0, 0, 0);
    idle();
    check("post_reset_run", oh(0), '0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model
    rst();
    check_model("random_reset");
    for (int seg = 0; seg < 40; seg++) begin
      p_evt   = int'($urandom_range(0, 30));
      p_start = int'($urandom_range(0, 2));
      for (int c = 0; c < 200; c++) begin
        for (int b = 0; b < N; b++) begin
          rd[b] = 1'(int'($urandom_range(0, 99)) < p_evt);
          rf[b] = 1'(int'($urandom_range(0, 99)) < p_evt / 3);
        end
        rs = 1'(int'($urandom_range(0, 99)) < p_start);
        ra = 1'($urandom_range(0, 199) < 2);
        rr = 1'($urandom_range(0, 999) < 2);
        cyc(rs, ra, rd, rf, rr);
        check_model("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
